// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Fetch looks up combinationally; the resolve stage trains it and gets mispredict feedback.
module branch_target_predictor #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  output logic              predict_hit,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_pred_taken,
  input  logic [ADDR_W-1:0] update_pred_target,
  input  logic              clear,
  output logic              mispredict,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic               r_mispredict;
  logic [CNT_W-1:0]   r_count;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_mis;

  // Lookup path: purely combinational from registered state, no bypass
  assign w_lk_idx       = lookup_pc[IDX_W-1:0];
  assign w_lk_tag       = lookup_pc[ADDR_W-1:IDX_W];
  assign predict_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign predict_taken  = predict_hit && r_ctr[w_lk_idx][CTR_W-1];
  assign predict_target = predict_taken ? r_target[w_lk_idx] : lookup_pc + ADDR_W'(1);

  assign w_up_idx = update_pc[IDX_W-1:0];
  assign w_up_tag = update_pc[ADDR_W-1:IDX_W];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_mis    = update_valid &&
                    ((update_pred_taken != update_taken) ||
                     (update_taken && (update_pred_target != update_target)));

  // Valid bits and direction counters; clear drops valid bits only
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
    end else if (clear) begin
      r_valid <= '0;
    end else if (update_valid) begin
      if (w_up_hit) begin
        if (update_taken) begin
          if (r_ctr[w_up_idx] != CTR_MAX) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + CTR_W'(1);
        end else if (r_ctr[w_up_idx] != '0) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - CTR_W'(1);
        end
      end else if (update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= CTR_WT;
      end
    end
  end

  // Tags and targets carry no reset; they are only meaningful behind a valid bit
  always_ff @(posedge CLK) begin
    if (update_valid && !clear && update_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= update_target;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mispredict <= 1'b0;
      r_count      <= '0;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis && (r_count != '1)) r_count <= r_count + CNT_W'(1);
    end
  end

  assign mispredict       = r_mispredict;
  assign mispredict_count = r_count;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, hand-written corner sequences,
// and a random phase checked against an entry-array reference model.
module tb_branch_target_predictor;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] lookup_pc = 16'h0;
  logic        predict_taken, predict_hit;
  logic [15:0] predict_target;
  logic        update_valid = 1'b0;
  logic [15:0] update_pc = 16'h0;
  logic        update_taken = 1'b0;
  logic [15:0] update_target = 16'h0;
  logic        update_pred_taken = 1'b0;
  logic [15:0] update_pred_target = 16'h0;
  logic        clear = 1'b0;
  logic        mispredict;
  logic [3:0]  mispredict_count;

  branch_target_predictor #(.ADDR_W(16), .ENTRIES(16), .CTR_W(2), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
    .predict_taken(predict_taken), .predict_target(predict_target), .predict_hit(predict_hit),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .clear(clear),
    .mispredict(mispredict), .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per entry, counters as plain integers
  bit          m_valid [16];
  int          m_tag   [16];
  int          m_tgt   [16];
  int          m_ctr   [16];
  bit          m_mis;
  int          m_cnt;

  typedef struct {
    logic        uv;
    logic [15:0] pc;
    logic        tk;
    logic [15:0] tgt;
    logic        pt;
    logic [15:0] ptg;
    logic        clr;
    logic [15:0] lk;
    logic        e_hit;
    logic        e_tk;
    logic [15:0] e_tgt;
    logic        e_mis;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_mis = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit uv, input int pc, input bit tk, input int tgt,
                                     input bit pt, input int ptg, input bit clr);
    int  idx;
    int  tag;
    bit  cond;
    idx  = pc % 16;
    tag  = pc / 16;
    cond = uv && ((pt != tk) || (tk && ptg != tgt));
    m_mis = cond;
    if (cond && m_cnt < 15) m_cnt++;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_valid[idx] && m_tag[idx] == tag) begin
        if (tk) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = tgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_tgt[idx]   = tgt;
        m_ctr[idx]   = 2;
      end
    end
  endfunction

  function automatic void model_predict(input int pc, output bit h, output bit t, output int g);
    int idx;
    idx = pc % 16;
    h = m_valid[idx] && m_tag[idx] == pc / 16;
    t = h && m_ctr[idx] >= 2;
    g = t ? m_tgt[idx] : (pc + 1) % 65536;
  endfunction

  // Drive one update cycle, advance the model at the edge, then idle the update inputs
  task automatic do_cycle(input bit uv, input logic [15:0] pc, input bit tk, input logic [15:0] tgt,
                          input bit pt, input logic [15:0] ptg, input bit clr);
    update_valid = uv; update_pc = pc; update_taken = tk; update_target = tgt;
    update_pred_taken = pt; update_pred_target = ptg; clear = clr;
    @(posedge CLK);
    model_edge(uv, int'(pc), tk, int'(tgt), pt, int'(ptg), clr);
    #1;
    update_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic check_model_lookup(input logic [15:0] pc);
    bit h, t;
    int g;
    lookup_pc = pc;
    #1;
    model_predict(int'(pc), h, t, g);
    chk("rand_hit", 32'(predict_hit), 32'(h));
    chk("rand_taken", 32'(predict_taken), 32'(t));
    chk("rand_target", 32'(predict_target), 32'(g));
  endtask

  initial begin
    // uv  pc        tk  tgt      pt  ptg      clr lookup    hit tk  target   mis cnt
    vecs[0]  = '{1'b1, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b0, 16'h0013, 1'b1, 1'b1, 16'h0040, 1'b1, 4'd1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0013, 1'b1, 1'b1, 16'h0040, 1'b0, 4'd1};
    vecs[2]  = '{1'b1, 16'h0013, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0013, 1'b1, 1'b0, 16'h0014, 1'b1, 4'd2};
    vecs[3]  = '{1'b1, 16'h0013, 1'b0, 16'h0040, 1'b0, 16'h0014, 1'b0, 16'h0013, 1'b1, 1'b0, 16'h0014, 1'b0, 4'd2};
    vecs[4]  = '{1'b1, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b0, 16'h0013, 1'b1, 1'b0, 16'h0014, 1'b1, 4'd3};
    vecs[5]  = '{1'b1, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b0, 16'h0013, 1'b1, 1'b1, 16'h0040, 1'b1, 4'd4};
    vecs[6]  = '{1'b1, 16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0013, 1'b1, 1'b1, 16'h0040, 1'b0, 4'd4};
    vecs[7]  = '{1'b1, 16'h0013, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0013, 1'b1, 1'b1, 16'h0040, 1'b1, 4'd5};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0023, 1'b0, 1'b0, 16'h0024, 1'b0, 4'd5};
    vecs[9]  = '{1'b1, 16'h0023, 1'b1, 16'h0099, 1'b0, 16'h0024, 1'b0, 16'h0023, 1'b1, 1'b1, 16'h0099, 1'b1, 4'd6};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0013, 1'b0, 1'b0, 16'h0014, 1'b0, 4'd6};
    vecs[11] = '{1'b1, 16'h0033, 1'b1, 16'h0055, 1'b0, 16'h0034, 1'b1, 16'h0033, 1'b0, 1'b0, 16'h0034, 1'b1, 4'd7};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0023, 1'b0, 1'b0, 16'h0024, 1'b0, 4'd7};
    vecs[13] = '{1'b1, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 1'b0, 4'd7};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFEF, 1'b0, 1'b0, 16'hFFF0, 1'b0, 4'd7};
    vecs[15] = '{1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd8};
    vecs[16] = '{1'b1, 16'hFFFF, 1'b1, 16'h2000, 1'b1, 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h2000, 1'b1, 4'd9};
    vecs[17] = '{1'b0, 16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0011, 1'b0, 4'd9};

    // Outputs while held in reset
    model_reset();
    lookup_pc = 16'h0010;
    #2;
    chk("rst_hit", 32'(predict_hit), 32'h0);
    chk("rst_taken", 32'(predict_taken), 32'h0);
    chk("rst_target", 32'(predict_target), 32'h0011);
    chk("rst_count", 32'(mispredict_count), 32'h0);
    chk("rst_mis", 32'(mispredict), 32'h0);
    #10 RST = 1'b1;
    @(posedge CLK); #1;

    // Directed vectors
    for (int v = 0; v < 18; v++) begin
      do_cycle(vecs[v].uv, vecs[v].pc, vecs[v].tk, vecs[v].tgt, vecs[v].pt, vecs[v].ptg, vecs[v].clr);
      chk($sformatf("vec%0d_mis", v), 32'(mispredict), 32'(vecs[v].e_mis));
      chk($sformatf("vec%0d_cnt", v), 32'(mispredict_count), 32'(vecs[v].e_cnt));
      lookup_pc = vecs[v].lk;
      #1;
      chk($sformatf("vec%0d_hit", v), 32'(predict_hit), 32'(vecs[v].e_hit));
      chk($sformatf("vec%0d_taken", v), 32'(predict_taken), 32'(vecs[v].e_tk));
      chk($sformatf("vec%0d_target", v), 32'(predict_target), 32'(vecs[v].e_tgt));
    end

    // Count saturation: 9 -> 15, then held
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b1, 16'h0005, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
      chk("sat_cnt", 32'(mispredict_count), (k < 6) ? 32'(10 + k) : 32'hF);
      chk("sat_mis", 32'(mispredict), 32'h1);
    end

    // Asynchronous reset mid-stream with a mispredicting update pending
    lookup_pc = 16'hFFFF;
    #1;
    chk("pre_rst_hit", 32'(predict_hit), 32'h1);
    update_valid = 1'b1; update_pc = 16'h0044; update_taken = 1'b1; update_target = 16'h0777;
    update_pred_taken = 1'b0; update_pred_target = 16'h0045;
    #1 RST = 1'b0;
    #1;
    chk("arst_cnt", 32'(mispredict_count), 32'h0);
    chk("arst_mis", 32'(mispredict), 32'h0);
    chk("arst_hit", 32'(predict_hit), 32'h0);
    chk("arst_target", 32'(predict_target), 32'h0000);
    model_reset();
    @(posedge CLK); #1;
    lookup_pc = 16'h0044;
    #1;
    chk("arst_discard_hit", 32'(predict_hit), 32'h0);
    chk("arst_hold_cnt", 32'(mispredict_count), 32'h0);
    update_valid = 1'b0;
    #2 RST = 1'b1;
    @(posedge CLK); #1;

    // Random phase against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] pc, tgt, ptg;
      bit          tk, pt, clr, uv, h, t;
      int          g;
      pc  = 16'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) pc = 16'hFFF0 | 16'($urandom_range(0, 15));
      uv  = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 2) != 0);
      tgt = 16'($urandom_range(0, 7) * 16'h0100);
      clr = ($urandom_range(0, 29) == 0);
      model_predict(int'(pc), h, t, g);
      pt  = t;
      ptg = 16'(g);
      if ($urandom_range(0, 4) == 0) pt = ~pt;
      if ($urandom_range(0, 4) == 0) ptg = 16'($urandom);
      do_cycle(uv, pc, tk, tgt, pt, ptg, clr);
      chk("rand_mis", 32'(mispredict), 32'(m_mis));
      chk("rand_cnt", 32'(mispredict_count), 32'(m_cnt));
      check_model_lookup(($urandom_range(0, 1) == 1) ? pc : 16'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters. It lets the fetch stage redirect PC speculatively instead of always flushing when a branch resolves in EX/MEM. Fetch queries it combinationally with the current PC. The resolve stage writes back actual outcomes and receives a registered mispredict pulse plus a running mispredict count.

Parameters:
ADDR_W, 16, PC/target width in bits; PC is word-addressed, sequential successor is PC+1.
ENTRIES, 16, number of direct-mapped entries; power of two, at least 2; IDX_W = log2(ENTRIES).
CTR_W, 2, direction counter width; taken prediction = counter MSB.
CNT_W, 16, mispredict counter width.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  reset, asynchronous, active-low.
lookup_pc  input  ADDR_W  PC being fetched this cycle.
predict_taken  output  1  combinational; 1 = redirect fetch to predict_target.
predict_target  output  ADDR_W  combinational next-PC prediction.
predict_hit  output  1  combinational; lookup_pc matches a valid entry.
update_valid  input  1  resolved branch/jump reported this cycle.
update_pc  input  ADDR_W  PC of the resolved instruction.
update_taken  input  1  actual direction.
update_target  input  ADDR_W  actual taken target.
update_pred_taken  input  1  predict_taken that fetch used for this instruction.
update_pred_target  input  ADDR_W  predict_target that fetch used.
clear  input  1  synchronous invalidate of all entries.
mispredict  output  1  registered one-cycle pulse.
mispredict_count  output  CNT_W  registered saturating count of mispredicts.

Behaviour:
- Index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W]. Entry = {valid, tag, target, ctr}.
- Lookup is purely combinational from registered state. There is no write-through bypass: a same-cycle update to the same index is visible on the next cycle only.
- predict_hit = valid[idx] && tag[idx]==lookup tag.
- predict_taken = predict_hit && ctr[idx][CTR_W-1].
- predict_target = predict_taken ? target[idx] : lookup_pc+1. The addition wraps modulo 2^ADDR_W (e.g. 16'hFFFF -> 16'h0000).
- Update on a rising CLK edge with update_valid=1 and clear=0:
  - Update hit, taken: ctr increments, saturating at 2^CTR_W-1; target <= update_target.
  - Update hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Update miss, taken: allocate. Set valid=1, tag, target <= update_target, ctr <= 2^(CTR_W-1) (weakly taken). Any aliasing entry is replaced.
  - Update miss, not taken: no change.
- clear=1: all valid bits <= 0 at the edge. clear has priority over a simultaneous update. Counters and mispredict_count are unaffected.
- Mispredict condition (evaluated on update inputs):
  - update_valid && (update_pred_taken != update_taken || (update_taken && update_pred_target != update_target)).
- mispredict <= condition at the edge, so the pulse appears 1 cycle after the update; it is 0 otherwise. The condition is evaluated even when clear=1.
- mispredict_count increments on each edge where the condition holds and saturates at all-ones.
- Reset (RST=0, asynchronous): all valid bits=0, all ctr=2^(CTR_W-1)-1 (weakly not-taken), mispredict=0, mispredict_count=0. Tags and targets need no reset.
- Reset asserted mid-update: state goes to reset values immediately; the update is discarded.
- Outputs during reset: predict_hit=0, predict_taken=0, predict_target=lookup_pc+1.
- Implement storage as flops; no RAM macros, because lookup is asynchronous.

Test Plan:
- Reset, then lookup_pc=16'h0010 -> predict_hit=0, predict_taken=0, predict_target=16'h0011, mispredict_count=0.
- Update pc=16'h0013, taken, target=16'h0040, pred_taken=0 -> next cycle: lookup 16'h0013 gives hit=1, taken=1, target=16'h0040; mispredict pulses for exactly 1 cycle; count=1.
- Same pc, update not-taken twice (pred_taken=1 then 0) -> after the first update ctr=01 and predict_taken=0 (predict_target=16'h0014); counts are 2 then 2. Three taken updates -> ctr saturates at 11; one not-taken keeps predict_taken=1.
- Alias: with 16'h0013 allocated, lookup 16'h0023 (same index, different tag) -> hit=0. Taken update of 16'h0023 -> replaces the entry; 16'h0013 now misses.
- clear=1 in the same cycle as a taken allocating update -> all entries invalid next cycle; the mispredict pulse still occurs if the condition holds.
- Force count to all-ones via repeated mispredicts (CNT_W=4 build) -> count holds at 4'hF. Assert RST low mid-stream -> count=0, mispredict=0, all misses, asynchronously without waiting for CLK.
